uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Receive-side controller for the full UART. Detects the start bit, sequences bit timing (half-bit then full-bit
//  sampling), counts received bits against the frame length, shifts samples, remaps to a data byte, raises RX_RDY.
//  Sits between the RX pin synchronizer and the CPU read interface.
// PARAMETERS
//  BAUD_W   20   width of BAUD_K (bit-time count in clk cycles)
// PORTS
//  clk         in   1       system clock, rising edge
//  reset       in   1       asynchronous, active-low reset; all state cleared while low
//  RX          in   1       serial input, asynchronous to clk, idle high
//  EIGHT       in   1       1 = 8 data bits, 0 = 7 data bits
//  PEN         in   1       parity enable
//  OHEL        in   1       parity select: 0 = even, 1 = odd
//  BAUD_K      in   BAUD_W  clk cycles per bit; values <2 are treated as 2
//  READ        in   1       1-cycle pulse: CPU consumed data; clears RX_RDY and the flags
//  RX_RDY      out  1       received byte valid (sticky until READ)
//  UART_RDATA  out  8       received data; bit 7 = 0 in 7-bit mode
//  PERR        out  1       parity error on the latched frame
//  FERR        out  1       framing error (stop bit sampled 0)
//  OVF         out  1       overrun: frame completed while RX_RDY was already 1
// BEHAVIOUR
//  - Reset: FSM=IDLE; all counters and shift reg 0; RX_RDY, UART_RDATA, PERR, FERR, OVF = 0; sync flops = 1.
//  - RX passes through a 2-flop synchronizer (rx_s); 2-cycle input latency.
//  - Bit timer btc: increments each cycle in START/RECV, clears in IDLE and on BTU. BTU = (btc == T-1),
//    T = BAUD_K>>1 in START, BAUD_K in RECV.
//  - FSM: IDLE: rx_s==0 -> START; latch EIGHT/PEN/OHEL (mid-frame config changes are ignored).
//    START: on BTU (mid start bit), rx_s==1 -> IDLE (false start, no flags); rx_s==0 -> RECV, bitcnt=0.
//    RECV: on BTU, sr <= {rx_s, sr[9:1]}, bitcnt++; when the incremented bitcnt == N -> DONE.
//    N = 8 + EIGHT + PEN (data + parity + stop; range 8..10). DONE: one cycle, latch outputs -> IDLE.
//  - Remap of sr in DONE, by {EIGHT,PEN}: 00 data={0,sr[8:2]}; 01 data={0,sr[7:1]}, par=sr[8];
//    10 data=sr[8:1]; 11 data=sr[7:0], par=sr[8]. Stop bit is always sr[9].
//  - RX_RDY rises the cycle after the final BTU (DONE cycle) and stays 1 until READ.
//  - READ with RX_RDY=0: no effect. READ in the same cycle as DONE: new frame wins (RX_RDY=1, new data);
//    OVF is not set.
//  - Overrun: DONE while RX_RDY=1 and no READ: UART_RDATA is overwritten, OVF=1.
//  - A new frame may start in the first IDLE cycle after DONE (back-to-back frames are supported).
//  - Reset mid-frame: immediate return to IDLE; partial frame discarded.
// CONFIGURATION
//  UART_RX_ERR_FLAGS_EN defined: PERR = PEN & (par != ^data ^ OHEL); FERR = ~sr[9]; OVF as above.
//    All three latch at DONE and clear on READ or reset.
//  Not defined: PERR, FERR and OVF are tied to 0; the parity/stop compare logic is not built; framing is unchanged.
// STRUCTURE
//  - Shared package uart_pkg: FSM state encoding (IDLE, START, RECV, DONE), frame-length constants,
//    config-bit field positions.
//  - One sub-module, uart_bit_timer: btc counter plus half/full target select, BTU output.
//    The bit counter, shift reg, remap and FSM stay in uart_rx_ctrl.
// TESTING (BAUD_K=16 unless stated)
//  1. 8N1, send 0xA5 -> RX_RDY rises 8+9*16 cycles (+sync) after the start edge; UART_RDATA=8'hA5; all flags 0.
//  2. 7E1, send 0x41 with parity bit 0 -> data=8'h41, PERR=0; repeat with parity bit 1 -> PERR=1.
//  3. 8O1, stop bit driven 0 -> UART_RDATA latched, FERR=1; READ pulse -> RX_RDY, FERR = 0 next cycle.
//  4. 3-cycle low glitch on idle RX -> returns to IDLE at half-bit; RX_RDY stays 0 and no frame is latched.
//  5. Two back-to-back 8N1 frames 0x11, 0x22, no READ -> RX_RDY=1, data=0x22, OVF=1.
//     Repeat with READ coincident with the 2nd DONE -> OVF=0.
//  6. reset low mid-data-bit 4 -> all outputs 0; after release, a full 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: FSM encoding, config field positions, frame length and sample remap for the UART receiver
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, RECV, DONE} state_t;
    localparam int CFG_OHEL = 0;
    localparam int CFG_PEN = 1;
    localparam int CFG_EIGHT = 2;
    localparam logic [3:0] FRAME_BASE = 4'd8;
    function automatic logic [3:0] frame_len(input logic eight, input logic pen);
        return FRAME_BASE + {3'b0, eight} + {3'b0, pen};
    endfunction
    function automatic logic [8:0] remap(input logic [9:0] sr, input logic eight, input logic pen);
        return eight ? (pen ? {sr[8], sr[7:0]} : {1'b0, sr[8:1]})
                     : (pen ? {sr[8], 1'b0, sr[7:1]} : {2'b0, sr[8:2]});
    endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-time counter; btu pulses at half a bit (half=1) or a full bit, BAUD_K clamped to >=2
module uart_bit_timer #(
    parameter int BAUD_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              half,
    input  logic [BAUD_W-1:0] baud_k,
    output logic              btu
);
    logic [BAUD_W-1:0] btc, k, t;
    assign k = (baud_k < BAUD_W'(2)) ? BAUD_W'(2) : baud_k;
    assign t = half ? k >> 1 : k;
    assign btu = run && (btc == t - BAUD_W'(1));
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) btc <= '0;
        else btc <= (!run || btu) ? '0 : btc + BAUD_W'(1);
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller (start detect, bit sampling, remap, RX_RDY and error flags)
// Ports: clk, reset (async active-low), RX serial in, EIGHT/PEN/OHEL frame config, BAUD_K bit time,
//        READ consume pulse; RX_RDY, UART_RDATA, PERR, FERR, OVF outputs.
// UART_RX_ERR_FLAGS_EN builds the parity/framing/overrun flags; otherwise they are tied to 0.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int BAUD_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RX,
    input  logic              EIGHT,
    input  logic              PEN,
    input  logic              OHEL,
    input  logic [BAUD_W-1:0] BAUD_K,
    input  logic              READ,
    output logic              RX_RDY,
    output logic [7:0]        UART_RDATA,
    output logic              PERR,
    output logic              FERR,
    output logic              OVF
);
    state_t      state;
    logic [1:0]  sync;
    logic        rx_s, btu;
    logic [2:0]  cfg;
    logic [3:0]  bitcnt, bitcnt_n, frame_n;
    logic [9:0]  sr;
    logic [8:0]  rm;
    assign rx_s = sync[1];
    assign bitcnt_n = bitcnt + 4'd1;
    assign frame_n = frame_len(cfg[CFG_EIGHT], cfg[CFG_PEN]);
    assign rm = remap(sr, cfg[CFG_EIGHT], cfg[CFG_PEN]);
    uart_bit_timer #(.BAUD_W(BAUD_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .run    (state == START || state == RECV),
        .half   (state == START),
        .baud_k (BAUD_K),
        .btu    (btu)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            sync <= 2'b11;
            cfg <= '0;
            bitcnt <= '0;
            sr <= '0;
            RX_RDY <= 1'b0;
            UART_RDATA <= '0;
        end else begin
            sync <= {sync[0], RX};
            if (READ && RX_RDY) RX_RDY <= 1'b0;
            case (state)
                IDLE: if (!rx_s) begin
                    state <= START;
                    cfg <= {EIGHT, PEN, OHEL};
                end
                START: if (btu) begin
                    state <= rx_s ? IDLE : RECV;
                    bitcnt <= '0;
                    sr <= '0;
                end
                RECV: if (btu) begin
                    sr <= {rx_s, sr[9:1]};
                    bitcnt <= bitcnt_n;
                    if (bitcnt_n == frame_n) state <= DONE;
                end
                default: begin
                    state <= IDLE;
                    RX_RDY <= 1'b1;
                    UART_RDATA <= rm[7:0];
                end
            endcase
        end
    end
`ifdef UART_RX_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PERR <= 1'b0;
            FERR <= 1'b0;
            OVF <= 1'b0;
        end else if (state == DONE) begin
            PERR <= cfg[CFG_PEN] & (rm[8] != (^rm[7:0] ^ cfg[CFG_OHEL]));
            FERR <= ~sr[9];
            OVF <= RX_RDY & ~READ;
        end else if (READ && RX_RDY) begin
            PERR <= 1'b0;
            FERR <= 1'b0;
            OVF <= 1'b0;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{rm[8], cfg[CFG_OHEL]};
    assign PERR = 1'b0;
    assign FERR = 1'b0;
    assign OVF = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: vector table, hand sequences and random frames against a bit-level frame model
module tb_uart_rx_ctrl;
    localparam int BW = 20;
`ifdef UART_RX_ERR_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif
    logic clk = 0, reset = 0, RX = 1, EIGHT = 1, PEN = 0, OHEL = 0, READ = 0;
    logic [BW-1:0] BAUD_K = 16;
    logic RX_RDY, PERR, FERR, OVF;
    logic [7:0] UART_RDATA;
    int passed = 0, total = 0, lat = 0;
    typedef struct {
        logic [7:0] d;
        logic e, p, o, par, stop;
        logic [7:0] xd;
        logic xpe, xfe;
    } vec_t;
    vec_t tbl[9];
    always #5 clk = ~clk;
    uart_rx_ctrl #(.BAUD_W(BW)) dut (
        .clk(clk), .reset(reset), .RX(RX), .EIGHT(EIGHT), .PEN(PEN), .OHEL(OHEL),
        .BAUD_K(BAUD_K), .READ(READ), .RX_RDY(RX_RDY), .UART_RDATA(UART_RDATA),
        .PERR(PERR), .FERR(FERR), .OVF(OVF)
    );
    function automatic int per();
        return (BAUD_K < 2) ? 2 : int'(BAUD_K);
    endfunction
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask
    task automatic send(input logic [7:0] d, input logic e, p, o, par, stop);
        logic bits[$];
        EIGHT = e; PEN = p; OHEL = o;
        bits.push_back(1'b0);
        for (int i = 0; i < (e ? 8 : 7); i++) bits.push_back(d[i]);
        if (p) bits.push_back(par);
        bits.push_back(stop);
        foreach (bits[i]) begin
            RX = bits[i];
            repeat (per()) @(negedge clk);
            if (i == 1) {EIGHT, PEN, OHEL} = 3'($urandom);
        end
        RX = 1'b1;
    endtask
    task automatic gap();
        repeat (per() * 3 + 10) @(negedge clk);
    endtask
    task automatic check_frame(input string tag, input logic [7:0] d, input logic pe, fe, ov);
        check({tag, ".rdy"}, RX_RDY, 1);
        check({tag, ".data"}, UART_RDATA, d);
        check({tag, ".perr"}, PERR, FLAGS & pe);
        check({tag, ".ferr"}, FERR, FLAGS & fe);
        check({tag, ".ovf"}, OVF, FLAGS & ov);
    endtask
    task automatic do_read(input string tag);
        READ = 1; @(negedge clk); READ = 0; @(negedge clk);
        check({tag, ".rd_rdy"}, RX_RDY, 0);
        check({tag, ".rd_flags"}, {PERR, FERR, OVF}, 0);
    endtask
    initial begin
        logic [7:0] v, d;
        logic e, p, o, par, stop, skip, rdy_m;
        int ks[6] = '{1, 2, 3, 5, 8, 16};
        tbl[0] = '{8'h41, 0, 1, 0, 0, 1, 8'h41, 0, 0};
        tbl[1] = '{8'h41, 0, 1, 0, 1, 1, 8'h41, 1, 0};
        tbl[2] = '{8'h3C, 1, 1, 1, 1, 0, 8'h3C, 0, 1};
        tbl[3] = '{8'hFF, 0, 0, 0, 0, 1, 8'h7F, 0, 0};
        tbl[4] = '{8'h80, 1, 1, 0, 1, 1, 8'h80, 0, 0};
        tbl[5] = '{8'h00, 0, 1, 1, 1, 1, 8'h00, 0, 0};
        tbl[6] = '{8'hFF, 1, 1, 1, 0, 1, 8'hFF, 1, 0};
        tbl[7] = '{8'h5A, 1, 0, 0, 0, 0, 8'h5A, 0, 1};
        tbl[8] = '{8'hC3, 0, 1, 0, 1, 1, 8'h43, 0, 0};
        repeat (4) @(negedge clk);
        check("reset.rdy", RX_RDY, 0);
        check("reset.data", UART_RDATA, 0);
        check("reset.flags", {PERR, FERR, OVF}, 0);
        reset = 1;
        repeat (5) @(negedge clk);
        fork
            send(8'hA5, 1, 0, 0, 0, 1);
            begin
                int n = 0;
                while (!RX_RDY && n < 400) begin @(negedge clk); n++; end
                lat = n;
            end
        join
        check("t1.latency_ok", (lat >= 152 && lat <= 158), 1);
        gap();
        check_frame("t1", 8'hA5, 0, 0, 0);
        do_read("t1");
        for (int i = 0; i < 9; i++) begin
            send(tbl[i].d, tbl[i].e, tbl[i].p, tbl[i].o, tbl[i].par, tbl[i].stop);
            gap();
            check_frame($sformatf("vec%0d", i), tbl[i].xd, tbl[i].xpe, tbl[i].xfe, 0);
            do_read($sformatf("vec%0d", i));
        end
        RX = 0; repeat (3) @(negedge clk); RX = 1;
        repeat (40) @(negedge clk);
        check("glitch.rdy", RX_RDY, 0);
        check("glitch.data", UART_RDATA, tbl[8].xd);
        send(8'h11, 1, 0, 0, 0, 1);
        send(8'h22, 1, 0, 0, 0, 1);
        gap();
        check_frame("b2b", 8'h22, 0, 0, 1);
        do_read("b2b");
        send(8'h11, 1, 0, 0, 0, 1);
        fork
            send(8'h22, 1, 0, 0, 0, 1);
            begin
                repeat (lat - 1) @(negedge clk);
                READ = 1; @(negedge clk); READ = 0;
            end
        join
        gap();
        check_frame("b2b_rd", 8'h22, 0, 0, 0);
        v = 8'h5A; EIGHT = 1; PEN = 0;
        RX = 0; repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin RX = v[i]; repeat (16) @(negedge clk); end
        RX = v[4]; repeat (8) @(negedge clk);
        reset = 0; repeat (2) @(negedge clk);
        check("rst_mid.rdy", RX_RDY, 0);
        check("rst_mid.data", UART_RDATA, 0);
        check("rst_mid.flags", {PERR, FERR, OVF}, 0);
        RX = 1; reset = 1; repeat (20) @(negedge clk);
        send(8'h5A, 1, 0, 0, 0, 1);
        gap();
        check_frame("rst_after", 8'h5A, 0, 0, 0);
        do_read("rst_after");
        rdy_m = 0;
        for (int i = 0; i < 30; i++) begin
            BAUD_K = BW'(ks[$urandom_range(0, 5)]);
            d = 8'($urandom); e = 1'($urandom); p = 1'($urandom); o = 1'($urandom);
            par = 1'($urandom); stop = ($urandom_range(0, 7) != 0);
            skip = ($urandom_range(0, 3) == 0);
            if (!skip && rdy_m) begin do_read($sformatf("rnd%0d", i)); rdy_m = 0; end
            send(d, e, p, o, par, stop);
            gap();
            v = e ? d : {1'b0, d[6:0]};
            check_frame($sformatf("rnd%0d", i), v, p && (par != (o ? ~^v : ^v)), !stop, rdy_m);
            rdy_m = 1;
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
